// File: rtl/uart_tx_drain.sv
// uart_tx_drain: FIFO-draining 8N1 UART transmitter.
//
// While the upstream show-ahead FIFO reports a byte, the transmitter captures
// the head byte, pops it with a one-cycle advance pulse and sends it LSB-first
// as one start bit, eight data bits and one stop bit. A frame in flight always
// completes. `enable` only blocks the decision to start a new frame.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   enable      permits new frames to start
//   data_avail  FIFO holds a byte; data_in is valid while high
//   data_in     FIFO head byte
//   adv         one-cycle FIFO pop, first cycle of the start bit
//   tx          serial line, idle high, registered
//   busy        high whenever a frame is in progress
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       data_avail,
    input  logic [7:0] data_in,
    output logic       adv,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_reg, state_next;
    logic [7:0]    shift_reg, shift_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [CW-1:0] baud_cnt_reg, baud_cnt_next;
    logic          tx_reg, tx_next;
    logic          adv_reg, adv_next;
    logic          bit_done;
    logic [2:0]    bit_idx_inc;

    assign bit_done    = (baud_cnt_reg == LAST);
    assign bit_idx_inc = bit_idx_reg + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            shift_reg    <= 8'h00;
            bit_idx_reg  <= 3'd0;
            baud_cnt_reg <= '0;
            tx_reg       <= 1'b1;
            adv_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            bit_idx_reg  <= bit_idx_next;
            baud_cnt_reg <= baud_cnt_next;
            tx_reg       <= tx_next;
            adv_reg      <= adv_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        bit_idx_next  = bit_idx_reg;
        // The baud counter free-runs inside a frame and wraps at each bit end.
        baud_cnt_next = bit_done ? '0 : baud_cnt_reg + CW'(1);
        tx_next       = tx_reg;
        adv_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                baud_cnt_next = '0;
                tx_next       = 1'b1;
                if (enable && data_avail) begin
                    // Capture and pop in the same decision; tx drops on the
                    // following cycle together with the adv pulse.
                    shift_next = data_in;
                    adv_next   = 1'b1;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_done) begin
                    bit_idx_next = 3'd0;
                    tx_next      = shift_reg[0];
                    state_next   = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_inc;
                        tx_next      = shift_reg[bit_idx_inc];
                    end
                end
            end
            STOP: begin
                // Always pass through IDLE so frames are spaced by 10N+1.
                if (bit_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign adv  = adv_reg;
    assign tx   = tx_reg;
    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_drain.sv
// Testbench for uart_tx_drain: two lanes (CLKS_PER_BIT = 4 and 2), each with
// a show-ahead FIFO model, a frame-timing reference model and a byte
// scoreboard decoded from the serial line.
module tb_uart_tx_drain;

    logic clk = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   done [2];

    initial forever #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int N = (gi == 0) ? 4 : 2;

        logic       rst = 1'b0;
        logic       enable = 1'b0;
        logic       data_avail = 1'b0;
        logic [7:0] data_in = 8'h00;
        logic       adv, tx, busy;

        logic [7:0] fifo [$];
        logic [7:0] exp_q [$];
        int         t = 0;          // cycle index within the current frame, 0 = idle
        logic [7:0] cur_byte = 8'h00;
        logic [7:0] rx = 8'h00;

        uart_tx_drain #(.CLKS_PER_BIT(N)) dut (
            .clk        (clk),
            .rst        (rst),
            .enable     (enable),
            .data_avail (data_avail),
            .data_in    (data_in),
            .adv        (adv),
            .tx         (tx),
            .busy       (busy)
        );

        task automatic refresh();
            data_avail = (fifo.size() != 0);
            data_in    = (fifo.size() != 0) ? fifo[0] : 8'h00;
        endtask

        task automatic push(input logic [7:0] b);
            fifo.push_back(b);
            exp_q.push_back(b);
            refresh();
        endtask

        // Expected line level in frame cycle tt: start bit, 8 data bits LSB first, stop bit.
        function automatic logic exp_tx(input int tt, input logic [7:0] b);
            int k;
            if (tt == 0) return 1'b1;
            k = (tt - 1) / N;
            if (k == 0) return 1'b0;
            if (k == 9) return 1'b1;
            return b[k-1];
        endfunction

        // FIFO: pops on a clock edge that samples adv high.
        initial begin : fifo_proc
            logic pop_now;
            forever begin
                @(posedge clk);
                pop_now = adv;
                #1;
                if (pop_now && fifo.size() != 0) begin
                    void'(fifo.pop_front());
                    refresh();
                end
            end
        end

        // Reference frame timing: a frame starts on an edge that sees idle,
        // enable and data_avail, and lasts 10N cycles.
        initial begin : model_proc
            forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    t = 0;
                end else if (t == 0) begin
                    if (enable && data_avail) begin
                        t  = 1;
                        rx = 8'h00;
                        if (exp_q.size() == 0) begin
                            chk($sformatf("L%0d scoreboard_underrun", gi), 1, 0);
                            cur_byte = 8'h00;
                        end else begin
                            cur_byte = exp_q.pop_front();
                        end
                    end
                end else begin
                    t = (t == 10 * N) ? 0 : t + 1;
                end
            end
        end

        // Monitor: compares outputs every cycle and decodes each frame's byte.
        initial begin : monitor_proc
            forever begin
                @(negedge clk);
                chk($sformatf("L%0d adv", gi), int'(adv), int'(t == 1));
                chk($sformatf("L%0d busy", gi), int'(busy), int'(t != 0));
                chk($sformatf("L%0d tx", gi), int'(tx), int'(exp_tx(t, cur_byte)));
                if (t >= N + 1 && t <= 9 * N && ((t - 1) % N) == N / 2)
                    rx[(t - 1) / N - 1] = tx;
                if (t == 10 * N)
                    chk($sformatf("L%0d byte", gi), int'(rx), int'(cur_byte));
            end
        end

        // Reset must act without waiting for a clock edge.
        initial begin : async_rst_proc
            forever begin
                @(posedge rst);
                #1;
                chk($sformatf("L%0d rst_tx", gi), int'(tx), 1);
                chk($sformatf("L%0d rst_busy", gi), int'(busy), 0);
                chk($sformatf("L%0d rst_adv", gi), int'(adv), 0);
            end
        end

        task automatic wait_drain();
            int k = 0;
            while ((fifo.size() != 0 || t != 0) && k < 5000) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("L%0d drain_in_time", gi), int'(k < 5000), 1);
        endtask

        initial begin : stim_proc
            int k;
            #2 rst = 1'b1;
            repeat (3) @(negedge clk);
            #1 rst = 1'b0;

            // Idle with nothing available.
            repeat (50) @(negedge clk);

            // Single byte.
            enable = 1'b1;
            push(8'hA5);
            wait_drain();

            // Back-to-back frames from a FIFO holding two bytes.
            push(8'h00);
            push(8'hFF);
            wait_drain();

            // Enable gating: held off, then released, then dropped mid-frame.
            enable = 1'b0;
            push(8'h3C);
            repeat (100) @(negedge clk);
            enable = 1'b1;
            repeat (3 * N) @(negedge clk);
            enable = 1'b0;
            wait_drain();
            enable = 1'b1;

            // Reset during data bit 3; the interrupted byte is not resent.
            push(8'hC3);
            push(8'h96);
            k = 0;
            while (t != 4 * N + 1 && k < 1000) begin
                @(negedge clk);
                k++;
            end
            chk($sformatf("L%0d reach_bit3", gi), int'(k < 1000), 1);
            @(posedge clk);
            #2 rst = 1'b1;
            @(negedge clk);
            #1 rst = 1'b0;
            wait_drain();

            // Randomized bytes with random enable toggling.
            for (int i = 0; i < 16; i++) begin
                for (int j = 0; j < int'($urandom_range(1, 3)); j++)
                    push(8'($urandom));
                for (int j = 0; j < int'($urandom_range(5, 60)); j++) begin
                    @(negedge clk);
                    #1 enable = ($urandom_range(0, 3) != 0);
                end
            end
            enable = 1'b1;
            wait_drain();

            // Continuous stream of one pattern.
            for (int i = 0; i < 6; i++)
                push(8'h5A);
            wait_drain();

            repeat (20) @(negedge clk);
            done[gi] = 1'b1;
        end
    end

    initial begin : final_proc
        int k = 0;
        while (!(done[0] && done[1]) && k < 60000) begin
            @(negedge clk);
            k++;
        end
        chk("lanes_finished", int'(done[0] && done[1]), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_drain.md
# uart_tx_drain

FIFO-draining 8N1 UART transmitter for the console mux. It sits directly downstream of the byte FIFO. While the FIFO reports data available, it takes the head byte, pops it with a one-cycle advance pulse, and serialises it LSB-first on the `tx` line. A per-channel `enable` lets the mux pause draining at frame boundaries without corrupting a byte in flight.

## Interface
- `CLKS_PER_BIT`, default 234: clock cycles per UART bit (27 MHz / 115200). Legal range 2..65535.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: when low, no new frame starts; a frame already in flight completes.
- `data_avail` in 1: FIFO has a byte; `data_in` is valid while this is high (show-ahead).
- `data_in` in 8: FIFO head byte (FIFO `data_out`).
- `adv` out 1: one-cycle pulse that pops the FIFO head; drives FIFO advance input.
- `tx` out 1: serial line, idle high; registered output.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, START, DATA, STOP.
- Registers:
  - shift[7:0]
  - bit_idx[2:0]
  - baud_cnt, width clog2(CLKS_PER_BIT), counting 0..CLKS_PER_BIT-1
- IDLE:
  - `tx`=1.
  - If `enable` & `data_avail` are sampled high: shift<=`data_in`, `adv`<=1, `tx`<=0, baud_cnt<=0, go to START.
  - Otherwise stay in IDLE.
- START: `tx`=0.
  - When baud_cnt==CLKS_PER_BIT-1: baud_cnt<=0, bit_idx<=0, `tx`<=shift[0], go to DATA.
- DATA: `tx`=shift[bit_idx].
  - At baud_cnt==CLKS_PER_BIT-1 with bit_idx<7: bit_idx++, next bit.
  - At baud_cnt==CLKS_PER_BIT-1 with bit_idx==7: `tx`<=1, go to STOP.
- STOP: `tx`=1.
  - At baud_cnt==CLKS_PER_BIT-1: go to IDLE.
  - STOP never chains directly to START.
- `adv` is high for exactly one cycle per frame: the first cycle of START. It is never asserted outside that cycle.
- Inputs are ignored outside IDLE.
  - `data_avail` may take up to 2 cycles to fall after `adv`; this is harmless because IDLE is not re-entered for at least 10*CLKS_PER_BIT cycles.
- `enable` falling mid-frame has no effect on the current frame. It only blocks the IDLE->START decision.
- `data_in` changing after capture has no effect; the byte is held in shift.
- Async reset:
  - Forces IDLE, `tx`=1, `adv`=0, `busy`=0, counters 0, shift 0.
  - Takes effect immediately, mid-frame included.
  - A byte already popped is lost and is not re-sent.
  - After reset deasserts, the first possible start is the next rising edge.

## Timing
- Reset values: `tx`=1, `adv`=0, `busy`=0.
- Start edge: let edge E sample IDLE & `enable` & `data_avail`.
  - From E+1: `tx`=0, `adv`=1 for exactly one cycle, `busy`=1.
- Bit timing:
  - Start bit: cycles E+1 .. E+N (N = CLKS_PER_BIT).
  - Data bit k (k=0..7): cycles E+1+(k+1)N .. E+(k+2)N.
  - Stop bit: cycles E+1+9N .. E+10N.
- Return to IDLE: at cycle E+10N+1, with `busy`=0 in that cycle.
  - That cycle's edge may start the next frame.
  - Back-to-back frame period is therefore 10N+1 cycles.
- Frame length is exactly 10N cycles of `busy`=1.
- Latency from `data_avail` rising (sampled while IDLE) to `tx` falling: 1 cycle.

## Test plan
- Reset/idle: assert `rst`, release, hold `data_avail`=0 for 50 cycles -> `tx`=1, `adv`=0, `busy`=0 throughout.
- Single byte, N=4: present 0xA5 with `data_avail`=1 for one pop -> `adv` high for exactly 1 cycle; `tx` sequence, each bit 4 cycles: 0, 1,0,1,0,0,1,0,1, 1; `busy` high 40 cycles.
- Back-to-back, N=4, with the real FIFO model holding 0x00 then 0xFF -> two `adv` pulses exactly 41 cycles apart; decoded bytes 0x00, 0xFF; FIFO empty afterwards with no third `adv`.
- Enable gating: `enable`=0 with `data_avail`=1 for 100 cycles -> no `adv`, `tx`=1. Raise `enable` -> frame starts on the next edge. Drop `enable` mid-frame -> frame still completes all 10 bits.
- Reset mid-frame, N=4: pulse `rst` during data bit 3 -> `tx`=1 and `busy`=0 immediately (async). The next queued FIFO byte is transmitted normally and the interrupted byte is not retransmitted.
- Minimum N=2: send 0x5A continuously -> correct 2-cycle bits, 21-cycle frame period, one `adv` per frame.
